// File: rtl/vector_seq_control_unit.sv
// Control unit for the scalar/vector datapath: decodes an instruction into a registered
// control word and expands vector ops into per-lane beats with valid/ready on both sides.
module vector_seq_control_unit #(
    parameter int unsigned LANES        = 4,
    parameter int unsigned VALU_LANES   = 4,
    parameter int unsigned JUMP_BUBBLES = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [1:0]               instruction_type_i,
    input  logic [1:0]               func_i,
    input  logic                     imm_i,
    input  logic                     vector_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [15:0]              ctrl_o,
    output logic [$clog2(LANES):0]   lane_idx_o,
    output logic                     lane_last_o,
    output logic                     illegal_o
);

    localparam int unsigned LW = $clog2(LANES) + 1;
    localparam int unsigned BW = (JUMP_BUBBLES > 1) ? $clog2(JUMP_BUBBLES + 1) : 1;

    localparam logic [LW-1:0] VmemLast = LW'(LANES - 1);
    localparam logic [LW-1:0] ValuLast = LW'(LANES - VALU_LANES);
    localparam logic [LW-1:0] ValuStep = LW'(VALU_LANES);
    localparam logic [LW-1:0] OneStep  = LW'(1);
    localparam logic [BW-1:0] BubLast  = (JUMP_BUBBLES > 0) ? BW'(JUMP_BUBBLES - 1) : '0;

    // Control word bit positions
    localparam int unsigned CJumpI     = 0;
    localparam int unsigned CJumpCI    = 1;
    localparam int unsigned CJumpCD    = 2;
    localparam int unsigned CMemToReg  = 3;
    localparam int unsigned CMemWrite  = 4;
    localparam int unsigned CImmSrc    = 5;
    localparam int unsigned CVectorOp  = 6;
    localparam int unsigned CAluSrc1   = 7;
    localparam int unsigned CAluSrc2   = 8;
    localparam int unsigned CRegVWrite = 9;
    localparam int unsigned CRegSWrite = 10;

    typedef enum logic [1:0] {
        StIdle,
        StBeat,
        StBubble
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     ctrl_q, ctrl_d;
    logic [LW-1:0]   lane_idx_q, lane_idx_d;
    logic [LW-1:0]   last_idx_q, last_idx_d;
    logic [LW-1:0]   step_q, step_d;
    logic            lane_last_q, lane_last_d;
    logic            illegal_q, illegal_d;
    logic [BW-1:0]   bub_q, bub_d;

    logic [15:0]     dec_ctrl;
    logic            dec_illegal;
    logic [LW-1:0]   dec_last;
    logic [LW-1:0]   dec_step;
    logic [LW-1:0]   lane_nxt;
    logic            jump_q;
    logic            accept;

    // Instruction decode
    always_comb begin
        dec_ctrl    = '0;
        dec_illegal = 1'b0;
        dec_last    = '0;
        dec_step    = OneStep;
        unique case (instruction_type_i)
            2'b00: begin
                if (func_i == 2'b00 && !imm_i) begin
                    dec_ctrl[CJumpCI] = 1'b1;
                    dec_ctrl[CImmSrc] = 1'b1;
                    dec_ctrl[12:11]   = 2'b11;
                end else if (func_i == 2'b00 && imm_i) begin
                    dec_ctrl[CJumpI] = 1'b1;
                end else if (func_i == 2'b01 && !imm_i) begin
                    dec_ctrl[CJumpCD] = 1'b1;
                    dec_ctrl[CImmSrc] = 1'b1;
                    dec_ctrl[12:11]   = 2'b11;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            2'b01: begin
                dec_ctrl[CImmSrc] = 1'b1;
                dec_ctrl[12:11]   = 2'b10;
                if (func_i == 2'b00) begin
                    dec_ctrl[CMemWrite] = 1'b1;
                end
                if (func_i == 2'b01) begin
                    dec_ctrl[CMemToReg] = 1'b1;
                    if (vector_i) begin
                        dec_ctrl[CRegVWrite] = 1'b1;
                    end else begin
                        dec_ctrl[CRegSWrite] = 1'b1;
                    end
                end
                if (vector_i) begin
                    dec_ctrl[CVectorOp] = 1'b1;
                    dec_ctrl[CAluSrc1]  = 1'b1;
                    dec_last            = VmemLast;
                end
            end
            2'b10: begin
                if (imm_i) begin
                    // Immediate ALU forms are always scalar; the vector flag is ignored.
                    dec_ctrl[CRegSWrite] = 1'b1;
                    dec_ctrl[CImmSrc]    = 1'b1;
                    dec_ctrl[12:11]      = 2'b10;
                    dec_ctrl[14:13]      = func_i;
                end else if (vector_i) begin
                    if (func_i != 2'b11) begin
                        dec_ctrl[CRegVWrite] = 1'b1;
                        dec_ctrl[CVectorOp]  = 1'b1;
                        dec_ctrl[CAluSrc1]   = 1'b1;
                        dec_ctrl[CAluSrc2]   = 1'b1;
                        dec_ctrl[12:11]      = 2'b01;
                        dec_ctrl[14:13]      = func_i;
                        dec_last             = ValuLast;
                        dec_step             = ValuStep;
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end else if (!func_i[1]) begin
                    dec_ctrl[CRegSWrite] = 1'b1;
                    dec_ctrl[12:11]      = 2'b01;
                    dec_ctrl[14:13]      = func_i;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    assign jump_q = |ctrl_q[CJumpCD:CJumpI];

    // Sequencer: next state and handshake outputs
    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        lane_idx_d  = lane_idx_q;
        last_idx_d  = last_idx_q;
        step_d      = step_q;
        lane_last_d = lane_last_q;
        illegal_d   = 1'b0;
        bub_d       = bub_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        accept      = 1'b0;
        lane_nxt    = lane_idx_q + step_q;

        unique case (state_q)
            StIdle: begin
                in_ready_o = 1'b1;
                accept     = in_valid_i;
            end
            StBeat: begin
                out_valid_o = 1'b1;
                in_ready_o  = out_ready_i && lane_last_q && !jump_q;
                if (out_ready_i) begin
                    if (!lane_last_q) begin
                        lane_idx_d  = lane_nxt;
                        lane_last_d = (lane_nxt == last_idx_q);
                    end else if (jump_q && JUMP_BUBBLES > 0) begin
                        state_d = StBubble;
                        bub_d   = '0;
                    end else if (in_valid_i && !jump_q) begin
                        accept = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StBubble: begin
                if (bub_q == BubLast) begin
                    state_d = StIdle;
                end else begin
                    bub_d = bub_q + BW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            state_d     = StBeat;
            ctrl_d      = dec_ctrl;
            lane_idx_d  = '0;
            last_idx_d  = dec_last;
            step_d      = dec_step;
            lane_last_d = (dec_last == '0);
            illegal_d   = dec_illegal;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            ctrl_q      <= '0;
            lane_idx_q  <= '0;
            last_idx_q  <= '0;
            step_q      <= OneStep;
            lane_last_q <= 1'b0;
            illegal_q   <= 1'b0;
            bub_q       <= '0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            lane_idx_q  <= lane_idx_d;
            last_idx_q  <= last_idx_d;
            step_q      <= step_d;
            lane_last_q <= lane_last_d;
            illegal_q   <= illegal_d;
            bub_q       <= bub_d;
        end
    end

    assign ctrl_o      = ctrl_q;
    assign lane_idx_o  = lane_idx_q;
    assign lane_last_o = lane_last_q;
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_vector_seq_control_unit.sv
// Directed bench for vector_seq_control_unit (LANES=4, VALU_LANES=2, JUMP_BUBBLES=2).
module tb_vector_seq_control_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  ity;
    logic [1:0]  fn;
    logic        imm;
    logic        vec;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] ctrl;
    logic [2:0]  lane_idx;
    logic        lane_last;
    logic        illegal;

    int n_cmp = 0;
    int n_bad = 0;

    vector_seq_control_unit #(
        .LANES        (4),
        .VALU_LANES   (2),
        .JUMP_BUBBLES (2)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .in_valid_i         (in_valid),
        .in_ready_o         (in_ready),
        .instruction_type_i (ity),
        .func_i             (fn),
        .imm_i              (imm),
        .vector_i           (vec),
        .out_valid_o        (out_valid),
        .out_ready_i        (out_ready),
        .ctrl_o             (ctrl),
        .lane_idx_o         (lane_idx),
        .lane_last_o        (lane_last),
        .illegal_o          (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] t, input logic [1:0] f, input logic i, input logic v);
        in_valid = 1'b1;
        ity      = t;
        fn       = f;
        imm      = i;
        vec      = v;
    endtask

    task automatic beat_chk(input string tag, input logic [15:0] c, input logic [2:0] li,
                            input logic ll, input logic ir);
        @(negedge clk);
        check_eq({tag, ".valid"}, out_valid, 1);
        check_eq({tag, ".ctrl"}, ctrl, c);
        check_eq({tag, ".lane_idx"}, lane_idx, li);
        check_eq({tag, ".lane_last"}, lane_last, ll);
        check_eq({tag, ".in_ready"}, in_ready, ir);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        ity       = 2'b00;
        fn        = 2'b00;
        imm       = 1'b0;
        vec       = 1'b0;
        out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        check_eq("rst.valid", out_valid, 0);
        check_eq("rst.ctrl", ctrl, 0);
        check_eq("rst.lane_idx", lane_idx, 0);
        check_eq("rst.lane_last", lane_last, 0);
        check_eq("rst.illegal", illegal, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst.in_ready", in_ready, 1);

        // Vector load: 4 beats, step 1
        cyc();
        send(2'b01, 2'b01, 1'b0, 1'b1);
        @(negedge clk);
        check_eq("vld.accept_rdy", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            beat_chk("vld", 16'h12E8, 3'(b), b == 3, b == 3);
            cyc();
        end
        @(negedge clk);
        check_eq("vld.done", out_valid, 0);

        // Scalar store
        cyc();
        send(2'b01, 2'b00, 1'b0, 1'b0);
        cyc();
        in_valid = 1'b0;
        beat_chk("sst", 16'h1030, 0, 1, 1);

        // Immediate ALU back-to-back x3
        cyc();
        send(2'b10, 2'b11, 1'b1, 1'b0);
        @(negedge clk);
        check_eq("b2b.accept_rdy", in_ready, 1);
        cyc();
        for (int k = 0; k < 3; k++) begin
            if (k == 2) in_valid = 1'b0;
            beat_chk("b2b", 16'h7420, 0, 1, 1);
            cyc();
        end
        @(negedge clk);
        check_eq("b2b.done", out_valid, 0);

        // JumpI followed by two bubbles, next instruction waiting
        cyc();
        send(2'b00, 2'b00, 1'b1, 1'b0);
        @(negedge clk);
        check_eq("jmp.accept_rdy", in_ready, 1);
        cyc();
        send(2'b10, 2'b01, 1'b0, 1'b0);
        beat_chk("jmp", 16'h0001, 0, 1, 0);
        cyc();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_eq("jmp.bubble_rdy", in_ready, 0);
            check_eq("jmp.bubble_valid", out_valid, 0);
            cyc();
        end
        @(negedge clk);
        check_eq("jmp.rdy_after", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        beat_chk("jmp.next", 16'h2C00, 0, 1, 1);
        cyc();
        @(negedge clk);
        check_eq("jmp.next_done", out_valid, 0);

        // Vector add, 2 beats with out_ready stalled 3 cycles on beat 0
        cyc();
        send(2'b10, 2'b00, 1'b0, 1'b1);
        cyc();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            beat_chk("vadd.hold", 16'h0BC0, 0, 0, 0);
            cyc();
        end
        out_ready = 1'b1;
        beat_chk("vadd.b0", 16'h0BC0, 0, 0, 0);
        cyc();
        beat_chk("vadd.b1", 16'h0BC0, 2, 1, 1);
        cyc();
        @(negedge clk);
        check_eq("vadd.done", out_valid, 0);

        // Illegal encoding: one beat, pulse, no bubbles
        cyc();
        send(2'b00, 2'b11, 1'b0, 1'b0);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("ill.valid", out_valid, 1);
        check_eq("ill.pulse", illegal, 1);
        check_eq("ill.ctrl", ctrl, 0);
        check_eq("ill.lane_last", lane_last, 1);
        check_eq("ill.in_ready", in_ready, 1);
        cyc();
        @(negedge clk);
        check_eq("ill.after_valid", out_valid, 0);
        check_eq("ill.after_pulse", illegal, 0);
        check_eq("ill.after_rdy", in_ready, 1);

        // Reset during beat 2 of a vector load
        cyc();
        send(2'b01, 2'b01, 1'b0, 1'b1);
        cyc();
        in_valid = 1'b0;
        beat_chk("rstmid.b0", 16'h12E8, 0, 0, 0);
        cyc();
        beat_chk("rstmid.b1", 16'h12E8, 1, 0, 0);
        cyc();
        @(negedge clk);
        check_eq("rstmid.b2_idx", lane_idx, 2);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rstmid.valid", out_valid, 0);
        check_eq("rstmid.ctrl", ctrl, 0);
        check_eq("rstmid.lane_idx", lane_idx, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        cyc();
        send(2'b01, 2'b01, 1'b0, 1'b1);
        @(negedge clk);
        check_eq("rstmid.rdy", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        beat_chk("rstmid.new", 16'h12E8, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
